// File: rtl/wb_pkg.sv
// Shared writeback types: result-source select codes and the queued entry layout.
package wb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;
  localparam logic [1:0] WB_SEL_RSV = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries; presents its contents oldest-first with a
// valid mask so the top can scan for bypass matches.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output logic [$clog2(DEPTH):0]           count,
  output wb_entry_t [DEPTH-1:0]            entries,
  output logic [DEPTH-1:0]                 valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Pointers are log2(DEPTH) bits wide, so natural overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entries[0] is the head (oldest); higher indices are progressively younger.
  always_comb begin
    entries = '0;
    valid   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PTR_W'(k)];
      valid[k]   = CNT_W'(k) < count;
    end
  end
endmodule

// File: rtl/wb_result_buffer.sv
// Writeback result buffer: source mux, drop/error handling, FIFO toward the register
// file, and operand bypass from queued-but-unwritten results.
module wb_result_buffer
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Wb_Valid,
  output logic              Wb_Ready,
  input  logic [ADDR_W-1:0] Wb_Rd,
  input  logic [1:0]        Wb_Sel,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] Mem_Data,
  input  logic [DATA_W-1:0] PC_Plus2,
  output logic              Wb_Err,
  output logic              Rf_We,
  output logic [ADDR_W-1:0] Rf_Addr,
  output logic [DATA_W-1:0] Rf_Data,
  input  logic              Rf_Ready,
  input  logic [ADDR_W-1:0] Byp_Addr_A,
  output logic              Byp_Hit_A,
  output logic [DATA_W-1:0] Byp_Data_A,
  input  logic [ADDR_W-1:0] Byp_Addr_B,
  output logic              Byp_Hit_B,
  output logic [DATA_W-1:0] Byp_Data_B
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  accept;
  logic                  push;
  logic                  pop;
  wb_entry_t             new_entry;
  logic [CNT_W-1:0]      count;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;

  assign Wb_Ready = rst_n & (count < CNT_W'(DEPTH));
  assign accept   = Wb_Valid & Wb_Ready;
  assign push     = accept & (Wb_Sel != WB_SEL_RSV) & (Wb_Rd != '0);
  assign pop      = Rf_We & Rf_Ready;

  always_comb begin
    new_entry      = '0;
    new_entry.addr = Wb_Rd;
    case (Wb_Sel)
      WB_SEL_ALU: new_entry.data = ALU_Result;
      WB_SEL_MEM: new_entry.data = Mem_Data;
      WB_SEL_PC:  new_entry.data = PC_Plus2;
      default:    new_entry.data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Wb_Err <= 1'b0;
    else        Wb_Err <= accept & (Wb_Sel == WB_SEL_RSV);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (new_entry),
    .pop        (pop),
    .count      (count),
    .entries    (entries),
    .valid      (valid)
  );

  assign Rf_We   = valid[0];
  assign Rf_Addr = valid[0] ? entries[0].addr : '0;
  assign Rf_Data = valid[0] ? entries[0].data : '0;

  // Scan oldest to youngest so the last (youngest) match overrides earlier ones.
  function automatic logic [DATA_W:0] byp_lookup(input logic [ADDR_W-1:0] addr,
                                                 input wb_entry_t [DEPTH-1:0] ent,
                                                 input logic [DEPTH-1:0] vld);
    logic [DATA_W:0] res;
    res = '0;
    for (int k = 0; k < DEPTH; k++)
      if (vld[k] && addr != '0 && ent[k].addr == addr)
        res = {1'b1, ent[k].data};
    return res;
  endfunction

  assign {Byp_Hit_A, Byp_Data_A} = byp_lookup(Byp_Addr_A, entries, valid);
  assign {Byp_Hit_B, Byp_Data_B} = byp_lookup(Byp_Addr_B, entries, valid);
endmodule

// File: tb/tb_wb_result_buffer.sv
// Bench for wb_result_buffer: directed scenarios plus random traffic against a queue model.
module tb_wb_result_buffer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Wb_Valid = 1'b0;
  logic        Wb_Ready;
  logic [2:0]  Wb_Rd = '0;
  logic [1:0]  Wb_Sel = '0;
  logic [15:0] ALU_Result = '0, Mem_Data = '0, PC_Plus2 = '0;
  logic        Wb_Err;
  logic        Rf_We;
  logic [2:0]  Rf_Addr;
  logic [15:0] Rf_Data;
  logic        Rf_Ready = 1'b0;
  logic [2:0]  Byp_Addr_A = '0, Byp_Addr_B = '0;
  logic        Byp_Hit_A, Byp_Hit_B;
  logic [15:0] Byp_Data_A, Byp_Data_B;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit [2:0]  addr;
    bit [15:0] data;
  } ent_t;
  ent_t q[$];
  bit   exp_err = 0;

  always #5 clk = ~clk;

  wb_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .Wb_Valid(Wb_Valid), .Wb_Ready(Wb_Ready), .Wb_Rd(Wb_Rd),
    .Wb_Sel(Wb_Sel), .ALU_Result(ALU_Result), .Mem_Data(Mem_Data), .PC_Plus2(PC_Plus2),
    .Wb_Err(Wb_Err), .Rf_We(Rf_We), .Rf_Addr(Rf_Addr), .Rf_Data(Rf_Data), .Rf_Ready(Rf_Ready),
    .Byp_Addr_A(Byp_Addr_A), .Byp_Hit_A(Byp_Hit_A), .Byp_Data_A(Byp_Data_A),
    .Byp_Addr_B(Byp_Addr_B), .Byp_Hit_B(Byp_Hit_B), .Byp_Data_B(Byp_Data_B)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference bypass: search queued results youngest first.
  function automatic bit [16:0] model_byp(input bit [2:0] addr);
    if (addr == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == addr) return {1'b1, q[i].data};
    return '0;
  endfunction

  task automatic check_outputs();
    bit [16:0] ba, bb;
    ba = model_byp(Byp_Addr_A);
    bb = model_byp(Byp_Addr_B);
    check_val("wb_ready", Wb_Ready, q.size() < DEPTH);
    check_val("rf_we", Rf_We, q.size() > 0);
    check_val("rf_addr", Rf_Addr, q.size() > 0 ? q[0].addr : 3'd0);
    check_val("rf_data", Rf_Data, q.size() > 0 ? q[0].data : 16'd0);
    check_val("wb_err", Wb_Err, exp_err);
    check_val("byp_hit_a", Byp_Hit_A, ba[16]);
    check_val("byp_data_a", Byp_Data_A, ba[15:0]);
    check_val("byp_hit_b", Byp_Hit_B, bb[16]);
    check_val("byp_data_b", Byp_Data_B, bb[15:0]);
  endtask

  task automatic step(input bit v, input bit [2:0] rd, input bit [1:0] sel,
                      input bit [15:0] a, input bit [15:0] m, input bit [15:0] p,
                      input bit rr, input bit [2:0] xa, input bit [2:0] xb);
    bit acc, pp;
    bit [15:0] d;
    @(negedge clk);
    Wb_Valid = v; Wb_Rd = rd; Wb_Sel = sel; ALU_Result = a; Mem_Data = m; PC_Plus2 = p;
    Rf_Ready = rr; Byp_Addr_A = xa; Byp_Addr_B = xb;
    #1;
    check_outputs();
    acc = v && (q.size() < DEPTH);
    pp  = (q.size() > 0) && rr;
    d   = (sel == 0) ? a : (sel == 1) ? m : p;
    @(posedge clk);
    exp_err = acc && (sel == 3);
    if (pp) void'(q.pop_front());
    if (acc && sel != 3 && rd != 0) q.push_back('{addr: rd, data: d});
  endtask

  task automatic idle(input bit rr, input bit [2:0] xa, input bit [2:0] xb);
    step(0, 0, 0, 0, 0, 0, rr, xa, xb);
  endtask

  initial begin
    #2;
    check_val("reset_ready", Wb_Ready, 1'b0);
    check_val("reset_rf_we", Rf_We, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Source select, register-file always ready.
    step(1, 3, 0, 16'h1234, 16'hdead, 16'hbeef, 1, 3, 0);
    step(1, 3, 1, 16'hdead, 16'h5678, 16'hbeef, 1, 3, 0);
    step(1, 3, 2, 16'hdead, 16'hbeef, 16'h0042, 1, 3, 0);
    repeat (2) idle(1, 3, 0);

    // Fill with register file stalled, attempt a third push, then drain.
    step(1, 1, 0, 16'hAAAA, 0, 0, 0, 1, 2);
    step(1, 2, 0, 16'hBBBB, 0, 0, 0, 1, 2);
    step(1, 6, 0, 16'hCCCC, 0, 0, 0, 1, 2);
    check_val("full_stall_depth", q.size(), DEPTH);
    repeat (3) idle(1, 1, 2);

    // Two results to the same register: youngest must be forwarded.
    step(1, 5, 0, 16'h1111, 0, 0, 0, 5, 0);
    step(1, 5, 0, 16'h2222, 0, 0, 0, 5, 0);
    idle(0, 5, 0);
    check_val("byp_young_a", Byp_Data_A, 16'h2222);
    repeat (3) idle(1, 5, 0);

    // Dropped results: R0 target and reserved select.
    step(1, 0, 0, 16'h7777, 0, 0, 1, 0, 4);
    step(1, 4, 3, 16'h8888, 0, 0, 1, 0, 4);
    idle(1, 0, 4);
    check_val("err_pulse", Wb_Err, 1'b1);
    idle(1, 0, 4);

    // Push and pop in the same cycle with one entry queued.
    step(1, 6, 0, 16'h0101, 0, 0, 0, 6, 7);
    step(1, 7, 1, 0, 16'h0202, 0, 1, 6, 7);
    check_val("simul_depth", q.size(), 1);
    repeat (2) idle(1, 6, 7);

    // Reset with two entries queued.
    step(1, 2, 0, 16'h3333, 0, 0, 0, 2, 3);
    step(1, 3, 0, 16'h4444, 0, 0, 0, 2, 3);
    @(negedge clk);
    Wb_Valid = 0; Rf_Ready = 1; Byp_Addr_A = 2; Byp_Addr_B = 3;
    rst_n = 1'b0;
    #1;
    check_val("rst_rf_we", Rf_We, 1'b0);
    check_val("rst_ready", Wb_Ready, 1'b0);
    check_val("rst_hit_a", Byp_Hit_A, 1'b0);
    check_val("rst_hit_b", Byp_Hit_B, 1'b0);
    q.delete();
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 2, 3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    repeat (3) idle(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
